// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: turns one RV32I load/store into a single word bus
// transaction, stalling the upstream pipeline until the access resolves.
module mem_stage_lsu #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [2:0]  funct3,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] rdata2M,
  input  logic [4:0]  waddrM,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic        bus_err,
  input  logic [31:0] bus_rdata,
  output logic        Stall,
  output logic [31:0] load_data,
  output logic        wb_valid,
  output logic [4:0]  waddrW,
  output logic        fault,
  output logic [1:0]  fault_cause
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_REQ  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] CAUSE_MIS = 2'b01;
  localparam logic [1:0] CAUSE_ERR = 2'b10;
  localparam logic [1:0] CAUSE_TMO = 2'b11;

  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic m;
    case (f3)
      F3_H, F3_HU: m = off[0];
      F3_W:        m = (off != 2'b00);
      default:     m = 1'b0;
    endcase
    return m;
  endfunction

  function automatic logic [3:0] byte_enable(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    case (f3)
      F3_B, F3_BU: be = 4'b0001 << off;
      F3_H, F3_HU: be = off[1] ? 4'b1100 : 4'b0011;
      default:     be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    case (f3)
      F3_B, F3_BU: w = {4{d[7:0]}};
      F3_H, F3_HU: w = {2{d[15:0]}};
      default:     w = d;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'b00:   b = d[7:0];
      2'b01:   b = d[15:8];
      2'b10:   b = d[23:16];
      2'b11:   b = d[31:24];
      default: b = d[7:0];
    endcase
    h = off[1] ? d[31:16] : d[15:0];
    case (f3)
      F3_B:    r = {{24{b[7]}}, b};
      F3_BU:   r = {24'h000000, b};
      F3_H:    r = {{16{h[15]}}, h};
      F3_HU:   r = {16'h0000, h};
      default: r = d;
    endcase
    return r;
  endfunction

  logic [1:0]  state_r;
  logic [1:0]  state_nxt_s;
  logic [7:0]  cnt_r;
  logic [2:0]  f3_r;
  logic [1:0]  off_r;
  logic [4:0]  waddr_r;
  logic        bus_req_r;
  logic        bus_we_r;
  logic [31:0] bus_addr_r;
  logic [3:0]  bus_be_r;
  logic [31:0] bus_wdata_r;
  logic [31:0] load_data_r;
  logic        wb_valid_r;
  logic [4:0]  waddr_w_r;
  logic        fault_r;
  logic [1:0]  cause_r;

  logic access_s;
  logic mis_s;
  logic start_s;
  logic mis_fault_s;
  logic resp_err_s;
  logic resp_ok_s;
  logic tmo_s;
  logic req_exit_s;
  logic stall_s;

  assign access_s = mem_rd | mem_wr;
  assign mis_s    = misaligned(funct3, ALUResultM[1:0]);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (access_s && !mis_s) begin
          state_nxt_s = ST_REQ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (bus_err || bus_ack || (cnt_r == TMO_LIMIT)) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Per-state strobes and the combinational pipeline stall
  always_comb begin
    start_s     = 1'b0;
    mis_fault_s = 1'b0;
    resp_err_s  = 1'b0;
    resp_ok_s   = 1'b0;
    tmo_s       = 1'b0;
    stall_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        start_s     = access_s && !mis_s;
        mis_fault_s = access_s && mis_s;
        stall_s     = access_s && !mis_s;
      end
      ST_REQ: begin
        resp_err_s = bus_err;
        resp_ok_s  = bus_ack && !bus_err;
        tmo_s      = !bus_ack && !bus_err && (cnt_r == TMO_LIMIT);
        stall_s    = 1'b1;
      end
      ST_DONE: stall_s = 1'b0;
      default: stall_s = 1'b0;
    endcase
  end

  assign req_exit_s = resp_err_s | resp_ok_s | tmo_s;
  // A pending reset must release the pipeline even while an access is held.
  assign Stall      = !rst && stall_s;

  // Wait counter, restarted on every bus request
  always_ff @(posedge clk) begin
    if (rst || start_s) begin
      cnt_r <= 8'd0;
    end else if (state_r == ST_REQ) begin
      cnt_r <= cnt_r + 8'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Bus request register and the transaction fields held for its whole life
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_req_r   <= 1'b0;
      bus_we_r    <= 1'b0;
      bus_addr_r  <= 32'h0000_0000;
      bus_be_r    <= 4'b0000;
      bus_wdata_r <= 32'h0000_0000;
      f3_r        <= 3'b000;
      off_r       <= 2'b00;
      waddr_r     <= 5'd0;
    end else if (start_s) begin
      bus_req_r   <= 1'b1;
      bus_we_r    <= mem_wr;
      bus_addr_r  <= {ALUResultM[31:2], 2'b00};
      bus_be_r    <= byte_enable(funct3, ALUResultM[1:0]);
      bus_wdata_r <= store_data(funct3, rdata2M);
      f3_r        <= funct3;
      off_r       <= ALUResultM[1:0];
      waddr_r     <= waddrM;
    end else if (req_exit_s) begin
      bus_req_r   <= 1'b0;
    end
  end

  // Writeback and fault reporting; pulses last one cycle, data holds
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_r  <= 1'b0;
      fault_r     <= 1'b0;
      cause_r     <= 2'b00;
      load_data_r <= 32'h0000_0000;
      waddr_w_r   <= 5'd0;
    end else begin
      wb_valid_r <= 1'b0;
      fault_r    <= 1'b0;
      if (mis_fault_s) begin
        fault_r <= 1'b1;
        cause_r <= CAUSE_MIS;
      end
      if (resp_err_s) begin
        fault_r <= 1'b1;
        cause_r <= CAUSE_ERR;
      end
      if (tmo_s) begin
        fault_r <= 1'b1;
        cause_r <= CAUSE_TMO;
      end
      if (resp_ok_s && !bus_we_r) begin
        wb_valid_r  <= 1'b1;
        load_data_r <= load_extract(f3_r, off_r, bus_rdata);
        waddr_w_r   <= waddr_r;
      end
    end
  end

  assign bus_req     = bus_req_r;
  assign bus_we      = bus_we_r;
  assign bus_addr    = bus_addr_r;
  assign bus_be      = bus_be_r;
  assign bus_wdata   = bus_wdata_r;
  assign load_data   = load_data_r;
  assign wb_valid    = wb_valid_r;
  assign waddrW      = waddr_w_r;
  assign fault       = fault_r;
  assign fault_cause = cause_r;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: stimulus pushes expected bus transactions and
// writeback/fault events into queues; a negedge monitor pops and compares them.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_rd, mem_wr;
  logic [2:0]  funct3;
  logic [31:0] ALUResultM, rdata2M;
  logic [4:0]  waddrM;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack, bus_err;
  logic [31:0] bus_rdata;
  logic        Stall;
  logic [31:0] load_data;
  logic        wb_valid;
  logic [4:0]  waddrW;
  logic        fault;
  logic [1:0]  fault_cause;

  mem_stage_lsu dut (
    .clk(clk), .rst(rst), .mem_rd(mem_rd), .mem_wr(mem_wr), .funct3(funct3),
    .ALUResultM(ALUResultM), .rdata2M(rdata2M), .waddrM(waddrM),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_err(bus_err), .bus_rdata(bus_rdata),
    .Stall(Stall), .load_data(load_data), .wb_valid(wb_valid), .waddrW(waddrW),
    .fault(fault), .fault_cause(fault_cause)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_exp_t;

  typedef struct packed {
    logic        wb;
    logic        flt;
    logic [1:0]  cause;
    logic [31:0] data;
    logic [4:0]  waddr;
  } res_exp_t;

  bus_exp_t bus_q[$];
  res_exp_t res_q[$];
  bus_exp_t be_m;
  res_exp_t re_m;
  logic     req_prev;
  int       nvec = 0;
  int       nbad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic eb(input logic [31:0] a, input logic we, input logic [3:0] be, input logic [31:0] wd);
    bus_q.push_back('{addr: a, we: we, be: be, wdata: wd});
  endtask

  task automatic er(input logic wb, input logic flt, input logic [1:0] c, input logic [31:0] d,
                    input logic [4:0] wa);
    res_q.push_back('{wb: wb, flt: flt, cause: c, data: d, waddr: wa});
  endtask

  // Monitor: bus transaction at bus_req rise, result at every wb_valid/fault pulse
  always @(negedge clk) begin
    if (rst) begin
      req_prev <= 1'b0;
    end else begin
      req_prev <= bus_req;
      if (bus_req && !req_prev) begin
        if (bus_q.size() == 0) begin
          nvec++;
          nbad++;
          $display("FAIL bus_unexpected: bus_req with addr %h, none expected", bus_addr);
        end else begin
          be_m = bus_q.pop_front();
          chk("bus_addr", bus_addr, be_m.addr);
          chk("bus_we", {31'd0, bus_we}, {31'd0, be_m.we});
          chk("bus_be", {28'd0, bus_be}, {28'd0, be_m.be});
          chk("bus_wdata", bus_wdata, be_m.wdata);
        end
      end
      if (wb_valid || fault) begin
        if (res_q.size() == 0) begin
          nvec++;
          nbad++;
          $display("FAIL res_unexpected: wb_valid %b fault %b cause %b, none expected",
                   wb_valid, fault, fault_cause);
        end else begin
          re_m = res_q.pop_front();
          chk("wb_valid", {31'd0, wb_valid}, {31'd0, re_m.wb});
          chk("fault", {31'd0, fault}, {31'd0, re_m.flt});
          if (re_m.flt) chk("fault_cause", {30'd0, fault_cause}, {30'd0, re_m.cause});
          if (re_m.wb) begin
            chk("load_data", load_data, re_m.data);
            chk("waddrW", {27'd0, waddrW}, {27'd0, re_m.waddr});
          end
        end
      end
    end
  end

  // Drive one instruction, answer the bus after ack_dly REQ cycles, count Stall/REQ cycles
  task automatic run(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [4:0] wa, input int ack_dly,
                     input logic ackv, input logic errv, input logic [31:0] rdat,
                     input int exp_stall, input int exp_req, input string nm);
    int  stall_n;
    int  req_n;
    bit  done;
    stall_n = 0;
    req_n   = 0;
    done    = 1'b0;
    @(posedge clk); #1;
    mem_rd = rd; mem_wr = wr; funct3 = f3; ALUResultM = addr; rdata2M = wd; waddrM = wa;
    for (int c = 0; c < 1000 && !done; c++) begin
      @(negedge clk);
      bus_ack = 1'b0;
      bus_err = 1'b0;
      if (bus_req) begin
        if (req_n == ack_dly) begin
          bus_ack   = ackv;
          bus_err   = errv;
          bus_rdata = rdat;
        end
        req_n++;
      end
      if (Stall) stall_n++;
      else done = 1'b1;
    end
    @(posedge clk); #1;
    mem_rd = 1'b0; mem_wr = 1'b0; bus_ack = 1'b0; bus_err = 1'b0;
    chk({nm, "_stall_cycles"}, 32'(stall_n), 32'(exp_stall));
    chk({nm, "_req_cycles"}, 32'(req_n), 32'(exp_req));
  endtask

  initial begin
    rst = 1'b1; mem_rd = 1'b1; mem_wr = 1'b0; funct3 = 3'b010; ALUResultM = 32'h0;
    rdata2M = 32'h0; waddrM = 5'd0; bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", {31'd0, Stall}, 32'd0);
    chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst_fault", {30'd0, fault, wb_valid}, 32'd0);
    chk("rst_load_data", load_data, 32'h0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; mem_rd = 1'b0;

    // LB sign-extended from byte 3, single-cycle ack
    eb(32'h0000_1000, 1'b0, 4'b1000, 32'h0);
    er(1'b1, 1'b0, 2'b00, 32'hFFFF_FF80, 5'd5);
    run(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0, 5'd5, 0, 1'b1, 1'b0, 32'h80AA_BBCC, 2, 1, "lb");
    // SH upper half, replicated halfword
    eb(32'h0000_2000, 1'b1, 4'b1100, 32'hABCD_ABCD);
    run(1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 5'd0, 0, 1'b1, 1'b0, 32'h0, 2, 1, "sh");
    // Misaligned LW
    er(1'b0, 1'b1, 2'b01, 32'h0, 5'd0);
    run(1'b1, 1'b0, 3'b010, 32'h0000_3001, 32'h0, 5'd3, -1, 1'b0, 1'b0, 32'h0, 0, 0, "lw_mis");
    // LHU with ack and err together after 3 wait cycles: error wins
    eb(32'h0000_4000, 1'b0, 4'b0011, 32'h0);
    er(1'b0, 1'b1, 2'b10, 32'h0, 5'd0);
    run(1'b1, 1'b0, 3'b101, 32'h0000_4000, 32'h0, 5'd7, 3, 1'b1, 1'b1, 32'h0000_F00D, 5, 4, "lhu_err");
    // LW with no response: timeout after counter reaches 255
    eb(32'h0000_5000, 1'b0, 4'b1111, 32'h0);
    er(1'b0, 1'b1, 2'b11, 32'h0, 5'd0);
    run(1'b1, 1'b0, 3'b010, 32'h0000_5000, 32'h0, 5'd8, -1, 1'b0, 1'b0, 32'h0, 257, 256, "lw_tmo");
    // LH sign-extended upper half
    eb(32'h0000_7000, 1'b0, 4'b1100, 32'h0);
    er(1'b1, 1'b0, 2'b00, 32'hFFFF_8001, 5'd10);
    run(1'b1, 1'b0, 3'b001, 32'h0000_7002, 32'h0, 5'd10, 0, 1'b1, 1'b0, 32'h8001_1234, 2, 1, "lh");
    // LBU byte 1 zero-extended
    eb(32'h0000_7000, 1'b0, 4'b0010, 32'h0);
    er(1'b1, 1'b0, 2'b00, 32'h0000_0056, 5'd11);
    run(1'b1, 1'b0, 3'b100, 32'h0000_7001, 32'h0, 5'd11, 0, 1'b1, 1'b0, 32'h1234_5678, 2, 1, "lbu");
    // SB byte 1 replicated
    eb(32'h0000_8000, 1'b1, 4'b0010, 32'hA5A5_A5A5);
    run(1'b0, 1'b1, 3'b000, 32'h0000_8001, 32'h0000_00A5, 5'd0, 0, 1'b1, 1'b0, 32'h0, 2, 1, "sb");
    // SW with 2 wait cycles; load_data must survive stores
    eb(32'h0000_9000, 1'b1, 4'b1111, 32'hCAFE_F00D);
    run(1'b0, 1'b1, 3'b010, 32'h0000_9000, 32'hCAFE_F00D, 5'd0, 2, 1'b1, 1'b0, 32'h0, 4, 3, "sw");
    chk("load_data_hold", load_data, 32'h0000_0056);
    chk("waddrW_hold", {27'd0, waddrW}, 32'd11);
    // SB that errors
    eb(32'h0000_8000, 1'b1, 4'b1000, 32'h1111_1111);
    er(1'b0, 1'b1, 2'b10, 32'h0, 5'd0);
    run(1'b0, 1'b1, 3'b000, 32'h0000_8003, 32'h0000_0011, 5'd0, 0, 1'b0, 1'b1, 32'h0, 2, 1, "sb_err");
    // Misaligned LH
    er(1'b0, 1'b1, 2'b01, 32'h0, 5'd0);
    run(1'b1, 1'b0, 3'b001, 32'h0000_7003, 32'h0, 5'd4, -1, 1'b0, 1'b0, 32'h0, 0, 0, "lh_mis");
    // LHU upper half zero-extended
    eb(32'h0000_4000, 1'b0, 4'b1100, 32'h0);
    er(1'b1, 1'b0, 2'b00, 32'h0000_8001, 5'd12);
    run(1'b1, 1'b0, 3'b101, 32'h0000_4002, 32'h0, 5'd12, 0, 1'b1, 1'b0, 32'h8001_FFFF, 2, 1, "lhu");

    // Reset on the 2nd REQ cycle abandons the access
    eb(32'h0000_6004, 1'b0, 4'b1111, 32'h0);
    @(posedge clk); #1;
    mem_rd = 1'b1; funct3 = 3'b010; ALUResultM = 32'h0000_6004; waddrM = 5'd9;
    repeat (3) @(negedge clk);
    chk("abort_req_before", {31'd0, bus_req}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_bus_req", {31'd0, bus_req}, 32'd0);
    chk("abort_stall", {31'd0, Stall}, 32'd0);
    chk("abort_pulses", {30'd0, fault, wb_valid}, 32'd0);
    chk("abort_load_data", load_data, 32'h0);
    chk("abort_waddrW", {27'd0, waddrW}, 32'd0);
    chk("abort_bus_fields", {bus_be, bus_we, 25'd0, fault_cause}, 32'h0);
    chk("abort_bus_addr", bus_addr ^ bus_wdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; mem_rd = 1'b0;

    // Next LW completes normally with one wait cycle
    eb(32'h0000_6004, 1'b0, 4'b1111, 32'h0);
    er(1'b1, 1'b0, 2'b00, 32'hDEAD_BEEF, 5'd9);
    run(1'b1, 1'b0, 3'b010, 32'h0000_6004, 32'h0, 5'd9, 1, 1'b1, 1'b0, 32'hDEAD_BEEF, 3, 2, "lw");

    repeat (4) @(posedge clk);
    chk("bus_q_left", 32'(bus_q.size()), 32'd0);
    chk("res_q_left", 32'(res_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

Interface
REQ-001 clk  in  1  clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 mem_rd / mem_wr  in  1 each  load / store present in MEM stage; never both high.
REQ-004 funct3  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-005 ALUResultM  in  32  byte address. rdata2M  in  32  store data. waddrM  in  5  load destination register.
REQ-006 bus_req  out  1; bus_we  out  1; bus_addr  out  32  word-aligned; bus_be  out  4; bus_wdata  out  32.
REQ-007 bus_ack  in  1; bus_err  in  1; bus_rdata  in  32.
REQ-008 Stall  out  1  drives the Stall input of all upstream pipeline registers, including the EX/MEM register.
REQ-009 load_data  out  32; wb_valid  out  1; waddrW  out  5; fault  out  1; fault_cause  out  2  (01 misaligned, 10 bus error, 11 timeout).
REQ-010 Parameter TIMEOUT, default 255: REQ cycles allowed without ack/err.

Function
REQ-011 States: IDLE, REQ, DONE; 2-bit registered state.
REQ-012 Misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=00; evaluated in IDLE only.
REQ-013 IDLE, (mem_rd|mem_wr), aligned -> REQ; latch bus_addr={addr[31:2],00}, bus_we=mem_wr, bus_be, bus_wdata, funct3, addr[1:0], waddrM.
REQ-014 IDLE, misaligned access -> stay IDLE; fault=1, cause=01 for exactly one cycle (next edge); no bus access; Stall stays 0.
REQ-015 bus_be: B = 0001<<addr[1:0]; H = 0011 (addr[1]=0) or 1100; W = 1111.
REQ-016 bus_wdata: B = byte replicated x4; H = halfword replicated x2; W = rdata2M.
REQ-017 bus_req = 1 exactly while state is REQ; bus_addr/we/be/wdata stable from REQ entry until exit.
REQ-018 REQ: bus_err=1 -> DONE, fault cause 10 (err wins over simultaneous ack).
REQ-019 REQ: bus_ack=1, bus_err=0 -> DONE; loads capture extracted bus_rdata into load_data.
REQ-020 REQ: 8-bit wait counter, cleared on REQ entry, +1 per REQ cycle; at count==TIMEOUT with no ack/err -> DONE, fault cause 11.
REQ-021 Load extract: byte/half selected by latched addr[1:0]; B/H sign-extend, BU/HU zero-extend, W unchanged.
REQ-022 DONE lasts one cycle, then IDLE unconditionally; no new access starts in DONE (same instruction still held).
REQ-023 In DONE: wb_valid=1 only for successful loads, waddrW=latched waddr; fault=1 on error/timeout; stores without error raise neither.
REQ-024 Stall = !rst & ((IDLE & (mem_rd|mem_wr) & aligned) | REQ); combinational; 0 in DONE so the pipeline advances exactly once.
REQ-025 Minimum latency: access in IDLE, ack on first REQ cycle -> DONE on 2nd edge; Stall high 2 cycles.
REQ-026 wb_valid and fault are single-cycle pulses; load_data/waddrW hold until next successful load.

Reset
REQ-027 rst=1 at an edge: state IDLE, bus_req 0, counter 0, wb_valid 0, fault 0, fault_cause 00, load_data 0, waddrW 0, bus_addr/be/wdata 0, bus_we 0.
REQ-028 rst mid-REQ abandons the access: bus_req low after that edge; no wb_valid or fault generated.
REQ-029 Stall forced 0 while rst=1.

Verification
REQ-030 LB addr 0x1003, ack 1st REQ cycle, bus_rdata 0x80AABBCC -> bus_be 1000, load_data 0xFFFFFF80, wb_valid 1 cycle, Stall high 2 cycles.
REQ-031 SH addr 0x2002, rdata2M 0x1234ABCD -> bus_be 1100, bus_wdata 0xABCDABCD, bus_we 1, no wb_valid, no fault.
REQ-032 LW addr 0x3001 -> no bus_req, fault 1 cycle cause 01, Stall never high.
REQ-033 LHU addr 0x4000, ack and err same cycle after 3 wait cycles -> fault cause 10, no wb_valid, Stall high 5 cycles.
REQ-034 LW, no ack for TIMEOUT cycles -> DONE, fault cause 11, bus_req deasserted, IDLE next cycle.
REQ-035 rst pulse on 2nd REQ cycle -> bus_req 0, Stall 0, outputs at reset values; next LW completes normally.
